sp_ram_bist_initiator: RTL and testbench

- Initiator-side engine for the single-port byte-enabled testbench RAM.
- Drives the RAM request port (en/addr/wdata/we/be) and checks the registered read data.
- Runs a self-contained three-pass test: full-word pattern write, per-word single-byte-lane overwrite, then pipelined read-back compare.
- Used in the core testbench to qualify instruction/data RAM instances and their byte-enable wiring before the core is released from reset.

---
 rtl/sp_ram_bist_initiator.sv | 148 ++++++++++++++
 tb/tb_sp_ram_bist_initiator.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sp_ram_bist_initiator.sv
// Self-contained BIST engine for a single-port byte-enabled RAM: full-word write,
// single-lane overwrite per word, then pipelined read-back against the expected image.
module sp_ram_bist_initiator #(
  parameter int ADDR_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [31:0]              seed_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  output logic [ADDR_WIDTH-1:0]    first_err_addr_o,
  output logic                     en_o,
  output logic [ADDR_WIDTH-1:0]    addr_o,
  output logic [31:0]              wdata_o,
  output logic                     we_o,
  output logic [3:0]               be_o,
  input  logic [31:0]              rdata_i
);

  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [WW-1:0] LAST_W = '1;

  typedef enum logic [2:0] {IDLE, WRITE, BYTE, READ, DRAIN, DONE} state_t;

  state_t                   state;
  logic [WW-1:0]            w;
  logic [31:0]              seed;
  logic [WW-1:0]            cmp_w;
  logic [31:0]              p_cur;
  logic [31:0]              exp_cmp;
  logic                     cmp_en;
  logic                     mismatch;
  logic [ERR_CNT_WIDTH-1:0] err_next;
  logic [ADDR_WIDTH-1:0]    first_next;

  function automatic logic [31:0] pattern_word(input logic [31:0] s, input logic [WW-1:0] idx);
    return s + 32'(idx);
  endfunction

  function automatic logic [31:0] lane_flip(input logic [31:0] p, input logic [1:0] lane);
    return p ^ (32'h0000_00FF << {lane, 3'b000});
  endfunction

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Read data always belongs to the previous word; entering DRAIN wraps w to 0,
  // so w-1 names word N-1 there as well.
  assign cmp_w   = w - 1'b1;
  assign p_cur   = pattern_word(seed, w);
  assign exp_cmp = lane_flip(pattern_word(seed, cmp_w), cmp_w[1:0]);
  assign busy_o  = (state == WRITE) || (state == BYTE) || (state == READ) || (state == DRAIN);

  always_comb begin
    cmp_en     = ((state == READ) && (w != '0)) || (state == DRAIN);
    mismatch   = cmp_en && (rdata_i != exp_cmp);
    err_next   = err_cnt_o;
    first_next = first_err_addr_o;
    if (mismatch) begin
      err_next = sat_inc(err_cnt_o);
      if (err_cnt_o == '0) first_next = {cmp_w, 2'b00};
    end
  end

  // RAM request decode from the registered state; idle cycles drive all zeros
  always_comb begin
    en_o    = 1'b0;
    we_o    = 1'b0;
    be_o    = 4'h0;
    addr_o  = '0;
    wdata_o = 32'h0;
    case (state)
      WRITE: begin
        en_o    = 1'b1;
        we_o    = 1'b1;
        be_o    = 4'hF;
        addr_o  = {w, 2'b00};
        wdata_o = p_cur;
      end
      BYTE: begin
        en_o    = 1'b1;
        we_o    = 1'b1;
        be_o    = 4'b0001 << w[1:0];
        addr_o  = {w, 2'b00};
        wdata_o = ~p_cur;
      end
      READ: begin
        en_o   = 1'b1;
        addr_o = {w, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      w                <= '0;
      seed             <= 32'h0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            seed             <= seed_i;
            w                <= '0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            state            <= WRITE;
          end
        end
        WRITE: begin
          w <= w + 1'b1;
          if (w == LAST_W) state <= BYTE;
        end
        BYTE: begin
          w <= w + 1'b1;
          if (w == LAST_W) state <= READ;
        end
        READ: begin
          err_cnt_o        <= err_next;
          first_err_addr_o <= first_next;
          w                <= w + 1'b1;
          if (w == LAST_W) state <= DRAIN;
        end
        DRAIN: begin
          err_cnt_o        <= err_next;
          first_err_addr_o <= first_next;
          done_o           <= 1'b1;
          pass_o           <= (err_next == '0);
          state            <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_ram_bist_initiator.sv
// Directed bench for sp_ram_bist_initiator with a behavioural byte-enabled RAM
// and optional single-bit corruption of the read data for words 10 and 20.
module tb_sp_ram_bist_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        busy, done, pass;
  logic [15:0] err_cnt;
  logic [7:0]  first_err_addr;
  logic        en, we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;

  logic [31:0] mem [0:63];
  logic [31:0] ram_q;
  logic [5:0]  q_word;
  logic        inject = 1'b0;

  int checks = 0;
  int failures = 0;
  int busy_cnt;
  logic [7:0]  c0_addr, c69_addr;
  logic [3:0]  c0_be, c69_be;
  logic [31:0] c0_wdata, c69_wdata;
  logic        c69_en, c69_we, c192_en;

  sp_ram_bist_initiator #(.ADDR_WIDTH(8), .ERR_CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .seed_i(seed),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt),
    .first_err_addr_o(first_err_addr), .en_o(en), .addr_o(addr),
    .wdata_o(wdata), .we_o(we), .be_o(be), .rdata_i(rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mem[addr[7:2]][8*i +: 8] <= wdata[8*i +: 8];
      end else begin
        ram_q  <= mem[addr[7:2]];
        q_word <= addr[7:2];
      end
    end
  end

  assign rdata = ram_q ^ {31'b0, inject && (q_word == 6'd10 || q_word == 6'd20)};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [31:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the negedge right after the start edge; index k is the k-th busy cycle.
  task automatic run_loop(input int pulse_at, input int rst_at);
    int k;
    k = 0;
    busy_cnt = 0;
    while (!done && k < 2000) begin
      if (k == 0)   begin c0_addr = addr; c0_be = be; c0_wdata = wdata; end
      if (k == 69)  begin c69_addr = addr; c69_be = be; c69_wdata = wdata; c69_en = en; c69_we = we; end
      if (k == 192) c192_en = en;
      start = (k == pulse_at);
      if (k == rst_at) begin
        check("pre_rst_addr", addr, 8'h78);
        check("pre_rst_en", en, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_en", en, 1'b0);
        check("rst_outs", {busy, done, pass, err_cnt, first_err_addr, addr, wdata, we, be}, '0);
        start = 1'b0;
        return;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("run_timeout", k < 2000, 1'b1);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, pass}, 3'b000);
    check("reset_err", {err_cnt, first_err_addr}, '0);
    check("reset_ram", {en, addr, wdata, we, be}, '0);
    rst = 1'b0;

    // seed 0, fault-free
    start_run(32'h0);
    check("start_busy", busy, 1'b1);
    run_loop(-1, -1);
    check("s0_busy_cycles", busy_cnt, 193);
    check("s0_status", {done, pass}, 2'b11);
    check("s0_err", err_cnt, 16'd0);
    check("s0_first", first_err_addr, 8'h00);
    check("s0_w0_write", {c0_addr, c0_be, c0_wdata}, {8'h00, 4'hF, 32'h0});
    check("s0_byte_w5", {c69_en, c69_we, c69_addr, c69_be, c69_wdata},
          {1'b1, 1'b1, 8'h14, 4'b0010, 32'hFFFF_FFFA});
    check("s0_drain_en", c192_en, 1'b0);
    check("s0_mem5", mem[5], 32'h0000_FF05);
    check("s0_mem63", mem[63], 32'hFF00_003F);
    check("done_ram_idle", {en, addr, wdata, we, be}, '0);

    // seed wrap, with an ignored start pulse mid-run
    start_run(32'hFFFF_FFFF);
    run_loop(50, -1);
    check("wrap_busy_cycles", busy_cnt, 193);
    check("wrap_pass", {done, pass, err_cnt}, {2'b11, 16'd0});
    check("wrap_mem0", mem[0], 32'hFFFF_FF00);
    check("wrap_mem1", mem[1], 32'h0000_FF00);

    // corrupted read data for words 10 and 20
    inject = 1'b1;
    start_run(32'h0);
    run_loop(-1, -1);
    check("inj_err", err_cnt, 16'd2);
    check("inj_first", first_err_addr, 8'h28);
    check("inj_status", {done, pass}, 2'b10);
    inject = 1'b0;

    // restart from DONE clears status on the start edge
    start_run(32'h1234_5678);
    check("restart_clear", {busy, done, pass, err_cnt, first_err_addr}, {3'b100, 16'd0, 8'd0});
    run_loop(-1, -1);
    check("restart_busy_cycles", busy_cnt, 193);
    check("restart_pass", {done, pass, err_cnt}, {2'b11, 16'd0});
    check("restart_mem0", mem[0], 32'h1234_5687);
    check("restart_mem7", mem[7], 32'hED34_567F);
    check("restart_mem62", mem[62], 32'h12CB_56B6);

    // asynchronous reset in WRITE at w=30, then a clean full run
    start_run(32'h0);
    run_loop(-1, 30);
    repeat (2) @(negedge clk);
    check("rst_hold", {busy, done, en}, 3'b000);
    rst = 1'b0;
    start_run(32'h0BAD_F00D);
    run_loop(-1, -1);
    check("post_rst_busy_cycles", busy_cnt, 193);
    check("post_rst_pass", {done, pass, err_cnt}, {2'b11, 16'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
